// File: rtl/test_vector_sequencer.sv
// Buffered stimulus sequencer for a netlist under test. Vectors and their
// expected responses are loaded into a FIFO while idle. On start, each vector
// is driven on dut_a, allowed to settle, and the response on dut_b is compared
// with the stored expectation. A saturating error count and a pass flag
// summarise the run.
module test_vector_sequencer #(
  parameter int VEC_W  = 2,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [VEC_W-1:0]         load_vec,
  input  logic                     load_exp,
  input  logic                     start,
  output logic [VEC_W-1:0]         dut_a,
  input  logic                     dut_b,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         err_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // Value of the wait counter on the final WAIT cycle of a vector.
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((SETTLE > 1) ? SETTLE - 2 : 0);
  localparam logic [CNT_W-1:0]  ERR_MAX   = '1;
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t              state;

  // FIFO storage and pointers
  logic [VEC_W-1:0]    mem_vec [DEPTH];
  logic                mem_exp [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  // Per-vector working state
  logic                cur_exp;
  logic [WCNT_W-1:0]   wait_cnt;

  // Control decodes
  logic                idle_like;
  logic                push;
  logic                launch;
  logic                next_vec;
  logic                pop;
  logic                mismatch;
  logic [CNT_W-1:0]    err_next;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign load_ready = idle_like && (level < LVL_FULL);
  assign push       = load_valid && load_ready;

  // A run starts only with something buffered; the head is popped on the
  // same edge that enters APPLY so dut_a is valid for the whole APPLY cycle.
  assign launch     = idle_like && start && (level != '0);
  assign next_vec   = (state == CHECK) && (level != '0);
  assign pop        = launch || next_vec;

  assign mismatch   = (state == CHECK) && (dut_b != cur_exp);
  assign err_next   = (mismatch && (err_count != ERR_MAX)) ? err_count + 1'b1 : err_count;

  // FIFO payload write.
  // NOTE: the storage array carries no reset; the pointers and level define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_vec[wr_ptr] <= load_vec;
      mem_exp[wr_ptr] <= load_exp;
    end
  end

  // FIFO pointers and occupancy.
  // NOTE: all state registers use non-blocking assignments so every update
  // reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dut_a     <= '0;
      cur_exp   <= 1'b0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state     <= APPLY;
            busy      <= 1'b1;
            err_count <= '0;
            dut_a     <= mem_vec[rd_ptr];
            cur_exp   <= mem_exp[rd_ptr];
          end
        end

        APPLY: begin
          wait_cnt <= '0;
          state    <= (SETTLE == 1) ? CHECK : WAIT;
        end

        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        CHECK: begin
          err_count <= err_next;
          if (next_vec) begin
            state   <= APPLY;
            dut_a   <= mem_vec[rd_ptr];
            cur_exp <= mem_exp[rd_ptr];
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_vector_sequencer.sv
// Scoreboard bench for test_vector_sequencer. Stimulus tasks push the
// hand-computed result of each run; monitors pop and compare on every done.
module tb_test_vector_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [1:0] load_vec = '0;
  logic       load_exp = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dut_a;
  logic       dut_b;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [3:0] level;

  // Response model: 0 -> AND of the vector, 1 -> stuck 0, 2 -> stuck 1
  logic [1:0] bmode = 2'd0;
  assign dut_b = (bmode == 2'd0) ? &dut_a : (bmode == 2'd2);

  test_vector_sequencer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_vec(load_vec), .load_exp(load_exp), .start(start), .dut_a(dut_a),
    .dut_b(dut_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .level(level)
  );

  // Deep instance for the saturation run
  logic       load_valid32 = 1'b0;
  logic       load_ready32;
  logic [1:0] load_vec32 = '0;
  logic       start32 = 1'b0;
  logic [1:0] dut_a32;
  logic       busy32, done32, pass32;
  logic [3:0] err_count32;
  logic [5:0] level32;

  test_vector_sequencer #(.DEPTH(32)) dut32 (
    .clk(clk), .rst(rst), .load_valid(load_valid32), .load_ready(load_ready32),
    .load_vec(load_vec32), .load_exp(1'b1), .start(start32), .dut_a(dut_a32),
    .dut_b(1'b0), .busy(busy32), .done(done32), .pass(pass32),
    .err_count(err_count32), .level(level32)
  );

  typedef struct {
    logic       pass;
    logic [3:0] err;
    int         cycles;
  } exp_t;

  exp_t q[$];
  exp_t q32[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0, done_base = 0;
  int done32_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the default instance
  int   busy_cnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_count++;
        check("done one cycle", prev_done, 0);
        if (q.size() == 0) begin
          check("unexpected done", done, 0);
        end else begin
          e = q.pop_front();
          check("run pass", pass, e.pass);
          check("run err_count", err_count, e.err);
          check("run busy cycles", busy_cnt, e.cycles);
          check("level after run", level, 0);
        end
        busy_cnt = 0;
      end
    end
    prev_done = done;
  end

  // Monitor for the deep instance
  int busy32_cnt = 0;
  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst) begin
      busy32_cnt = 0;
    end else begin
      if (busy32) busy32_cnt++;
      if (done32) begin
        done32_count++;
        if (q32.size() == 0) begin
          check("unexpected done32", done32, 0);
        end else begin
          e = q32.pop_front();
          check("run32 pass", pass32, e.pass);
          check("run32 err_count", err_count32, e.err);
          check("run32 busy cycles", busy32_cnt, e.cycles);
        end
        busy32_cnt = 0;
      end
    end
  end

  task automatic load(input logic [1:0] v, input logic e);
    load_valid = 1'b1;
    load_vec   = v;
    load_exp   = e;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Pulse start for one cycle and record the expected run outcome.
  task automatic kick(input logic p, input logic [3:0] e, input int cyc);
    q.push_back('{p, e, cyc});
    done_base = done_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && done_count == done_base; i++) @(negedge clk);
    check("run completes", done_count > done_base, 1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int bad;
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset level", level, 0);
    check("reset dut_a", dut_a, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset err_count", err_count, 0);
    check("reset load_ready", load_ready, 1);

    // Two matching vectors under AND response: 6 busy cycles, pass
    bmode = 2'd0;
    load(2'd3, 1'b1);
    load(2'd1, 1'b0);
    check("level after 2 loads", level, 2);
    kick(1'b1, 4'd0, 6);
    wait_done();
    check("dut_a retained", dut_a, 1);

    // Three mismatches with stuck-0 response
    bmode = 2'd1;
    load(2'd1, 1'b1);
    load(2'd2, 1'b1);
    load(2'd0, 1'b1);
    kick(1'b0, 4'd3, 9);
    wait_done();

    // Matching rerun clears the count on start
    bmode = 2'd2;
    load(2'd1, 1'b1);
    load(2'd2, 1'b1);
    load(2'd0, 1'b1);
    kick(1'b1, 4'd0, 9);
    check("err cleared at start", err_count, 0);
    check("busy at start", busy, 1);
    wait_done();

    // DEPTH+2 loads with load_valid held: only 8 accepted
    bmode = 2'd0;
    load_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      load_vec = 2'(i);
      load_exp = i[0];
      @(negedge clk);
    end
    check("level full", level, 8);
    check("load_ready when full", load_ready, 0);
    // Vectors 1 and 5 (vec=1, exp=1) mismatch under AND response
    kick(1'b0, 4'd2, 24);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (load_ready) bad = 1;
      @(negedge clk);
    end
    load_valid = 1'b0;
    check("no load_ready during run", bad, 0);
    wait_done();
    check("level after held-valid run", level, 0);

    // Start with empty FIFO is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (6) begin
      if (busy) bad = 1;
      @(negedge clk);
    end
    check("empty start no busy", bad, 0);
    check("empty start pass kept", pass, 0);
    check("empty start err kept", err_count, 2);

    // Start during a run does not change its length
    load(2'd3, 1'b1);
    load(2'd0, 1'b0);
    kick(1'b1, 4'd0, 6);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);

    // Separate runs of 8, 8 and 2 mismatches are not summed
    bmode = 2'd1;
    for (int i = 0; i < 8; i++) load(2'(i), 1'b1);
    kick(1'b0, 4'd8, 24);
    wait_done();
    for (int i = 0; i < 8; i++) load(2'(i), 1'b1);
    kick(1'b0, 4'd8, 24);
    wait_done();
    load(2'd1, 1'b1);
    load(2'd2, 1'b1);
    kick(1'b0, 4'd2, 6);
    wait_done();

    // 18 mismatches in one run on the deep instance saturate at 15
    load_valid32 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      load_vec32 = 2'(i);
      @(negedge clk);
    end
    load_valid32 = 1'b0;
    check("level32 after 18 loads", level32, 18);
    q32.push_back('{1'b0, 4'd15, 54});
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 200 && done32_count == 0; i++) @(negedge clk);
    check("run32 completes", done32_count, 1);

    // Reset during WAIT of vector 2 of 4 aborts the run
    bmode = 2'd1;
    for (int i = 0; i < 4; i++) load(2'(i + 1), 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy before abort", busy, 1);
    check("err before abort", err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort level", level, 0);
    check("abort dut_a", dut_a, 0);
    check("abort err_count", err_count, 0);
    check("abort done", done, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort stays idle", busy, 0);

    check("scoreboard drained", q.size(), 0);
    check("scoreboard32 drained", q32.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
